cache_pmem_arbiter: RTL and testbench
=====================================

# cache_pmem_arbiter

Arbitrates the single 128-bit physical-memory port between the instruction cache and the data cache of the pipelined LC-3b. Each cache presents line-fill reads (and the D-cache write-backs) on its own pmem-side port. The arbiter grants one at a time, registers the winning request, drives physical memory, and routes the response and line data back to the winner. Cache-side word extraction from the returned line is unchanged downstream.

## Interface
- LINE_WIDTH, 128, cache line / pmem data width in bits
- ADDR_WIDTH, 16, byte address width
- clk  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_pmem_read  in  1  I-cache line-fill request, held until i_pmem_resp
- i_pmem_address  in  ADDR_WIDTH  I-cache line address
- i_pmem_rdata  out  LINE_WIDTH  line data to I-cache
- i_pmem_resp  out  1  one-cycle completion pulse to I-cache
- d_pmem_read  in  1  D-cache line-fill request
- d_pmem_write  in  1  D-cache write-back request
- d_pmem_address  in  ADDR_WIDTH  D-cache line address
- d_pmem_wdata  in  LINE_WIDTH  D-cache write-back line
- d_pmem_rdata  out  LINE_WIDTH  line data to D-cache
- d_pmem_resp  out  1  one-cycle completion pulse to D-cache
- pmem_read  out  1  read strobe to physical memory
- pmem_write  out  1  write strobe to physical memory
- pmem_address  out  ADDR_WIDTH  registered granted address
- pmem_wdata  out  LINE_WIDTH  registered granted write data
- pmem_rdata  in  LINE_WIDTH  memory read data, valid with pmem_resp
- pmem_resp  in  1  memory completion, one-cycle pulse

## Operation
- FSM states:
  - IDLE: no grant; evaluates requests.
  - SERVE_I: I-cache read granted.
  - SERVE_D: D-cache read or write granted.
  - RELEASE: one-cycle gap after completion.
- IDLE exit:
  - Only I pending: go to SERVE_I.
  - Only D pending: go to SERVE_D.
  - Both pending: grant the requester not in last_grant (round-robin).
  - Neither pending: stay in IDLE.
- last_grant is a 1-bit register, updated on every grant; reset value I, so D wins the first tie.
- On entry to SERVE_x, latch into registers: address, wdata, and operation (read/write).
- d_pmem_read and d_pmem_write both high: latch as write; the read is ignored.
- SERVE_x, pmem_resp=0: hold the state.
- SERVE_x, pmem_resp=1: go to RELEASE.
  - The granted client's resp is driven combinationally from pmem_resp.
  - The granted client's rdata is driven from pmem_rdata in the same cycle.
- RELEASE always goes to IDLE. This lets the client drop its request before re-evaluation, so no stale re-grant.
- Non-granted client: rdata=0, resp=0.
- A client dropping its request mid-grant does not abort the transaction; it runs to pmem_resp and the resp pulse is still issued.
- pmem_read/pmem_write are asserted only in SERVE_x, from the latched operation.

## Timing
- Reset (asynchronous, any state): state=IDLE, last_grant=I, latched address/wdata/op=0; all outputs 0.
- Request visible at edge N in IDLE: pmem strobe high from cycle N+1.
- Memory answering in L cycles: client resp coincides with pmem_resp. The next grant is evaluated two cycles after resp (RELEASE, then IDLE).
- Strobes stay high continuously until pmem_resp; address/wdata are stable for the whole grant.
- pmem_resp outside SERVE_x is ignored; no client resp is generated.

## Structure
- Shared package lc3b_types gains:
  - lc3b_line, a 128-bit line typedef;
  - an arbiter state enum {IDLE, SERVE_I, SERVE_D, RELEASE};
  - a grant enum {GRANT_I, GRANT_D}.
- The existing lc3b_word type is reused.
- No sub-module: FSM, request latch and return mux live in a single module.

## Test plan
- Single I-read: i_pmem_read=1, addr 0x1230, memory resp after 3 cycles with data 0x…DEAD -> pmem_read high 3 cycles; i_pmem_resp 1 pulse with rdata 0x…DEAD; d_pmem_resp stays 0.
- Simultaneous first requests after reset: I read 0x0040 and D read 0x8000 -> D served first, then I.
  - Grants 2 cycles apart after D's resp.
  - pmem_address sequence 0x8000, 0x0040.
- D write-back: d_pmem_write=1, addr 0x7F00, wdata 0xA5…A5 -> pmem_write=1, pmem_read=0, pmem_wdata=0xA5…A5; d_pmem_resp on pmem_resp.
- Round-robin under load: both clients request continuously for 6 transactions -> grants alternate D,I,D,I,D,I.
- Robustness: D drops its request mid-grant and changes address -> pmem_address holds the latched value until resp. Separately, a stray pmem_resp in IDLE -> no client resp.
- Reset mid-transaction: reset_n low during SERVE_I -> pmem_read=0 immediately; after release the state is IDLE and a tie grants D.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions: datapath words, cache lines and the
// enums used by the physical-memory arbiter.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RELEASE
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

endpackage

// File: rtl/cache_pmem_arbiter.sv
// Shares the single physical-memory port between the I-cache and D-cache,
// one registered grant at a time with round-robin tie breaking.
module cache_pmem_arbiter
  import lc3b_types::*;
#(
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,

  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,

  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  arb_state_t state;
  grant_t     last_grant;
  logic       op_write;

  logic i_req;
  logic d_req;
  logic pick_d;
  logic serving_i;
  logic serving_d;

  assign i_req  = i_pmem_read;
  assign d_req  = d_pmem_read | d_pmem_write;
  // D wins when alone, or on a tie when I was the last one served.
  assign pick_d = d_req && (!i_req || (last_grant == GRANT_I));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      last_grant   <= GRANT_I;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      op_write     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            state        <= SERVE_D;
            last_grant   <= GRANT_D;
            pmem_address <= d_pmem_address;
            pmem_wdata   <= d_pmem_wdata;
            // A simultaneous read+write is treated as a write-back.
            op_write     <= d_pmem_write;
          end else if (i_req) begin
            state        <= SERVE_I;
            last_grant   <= GRANT_I;
            pmem_address <= i_pmem_address;
            pmem_wdata   <= '0;
            op_write     <= 1'b0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            state <= RELEASE;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign serving_i = (state == SERVE_I);
  assign serving_d = (state == SERVE_D);

  assign pmem_read  = (serving_i | serving_d) & ~op_write;
  assign pmem_write = serving_d & op_write;

  // Responses are steered only to the current winner; memory responses
  // arriving outside a grant never reach either cache.
  assign i_pmem_resp  = serving_i & pmem_resp;
  assign d_pmem_resp  = serving_d & pmem_resp;
  assign i_pmem_rdata = serving_i ? pmem_rdata : '0;
  assign d_pmem_rdata = serving_d ? pmem_rdata : '0;

endmodule

// File: tb/tb_cache_pmem_arbiter.sv
// Directed bench for cache_pmem_arbiter: expected grants are queued as
// requests are raised and compared as the memory side completes them.
module tb_cache_pmem_arbiter;
  import lc3b_types::*;

  logic         clk;
  logic         reset_n;
  logic         i_pmem_read;
  logic [15:0]  i_pmem_address;
  logic [127:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [15:0]  d_pmem_address;
  logic [127:0] d_pmem_wdata;
  logic [127:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  typedef struct {
    grant_t       who;
    logic [15:0]  addr;
    logic         write;
    logic [127:0] wdata;
    logic [127:0] rdata;
  } sb_item_t;

  sb_item_t sb[$];
  int vectors;
  int miscompares;

  cache_pmem_arbiter #(.LINE_WIDTH(128), .ADDR_WIDTH(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] pattern(input logic [15:0] a);
    return {8{a}} ^ 128'hC3C3_0F0F_5A5A_1234_8765_F0F0_3C3C_A5A5;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input grant_t who, input logic [15:0] addr, input logic write,
                      input logic [127:0] wdata, input logic [127:0] rdata);
    sb_item_t e;
    e.who = who; e.addr = addr; e.write = write; e.wdata = wdata; e.rdata = rdata;
    sb.push_back(e);
  endtask

  // Acts as physical memory for one grant: waits for the strobe, holds it
  // for 'latency' cycles, then returns the queued line with pmem_resp.
  task automatic serve(input int exp_wait, input int latency, input bit keep_req, input bit drop_mid);
    sb_item_t e;
    int waited;
    bit seen;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    waited = 0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      waited++;
      if (pmem_read || pmem_write) seen = 1;
    end
    check("grant_seen", seen, 1);
    if (!seen) return;
    if (exp_wait != 0) check("grant_wait", waited, exp_wait);
    for (int c = 1; c <= latency; c++) begin
      if (c > 1) @(negedge clk);
      check("pmem_address", pmem_address, e.addr);
      check("pmem_read", pmem_read, !e.write);
      check("pmem_write", pmem_write, e.write);
      if (e.write) check("pmem_wdata", pmem_wdata, e.wdata);
      if (c == latency) begin
        pmem_rdata = e.rdata;
        pmem_resp = 1'b1;
        #1;
        check("i_resp", i_pmem_resp, e.who == GRANT_I);
        check("d_resp", d_pmem_resp, e.who == GRANT_D);
        if (e.who == GRANT_I) begin
          check("i_rdata", i_pmem_rdata, e.rdata);
          check("d_rdata_idle", d_pmem_rdata, 128'h0);
        end else begin
          check("d_rdata", d_pmem_rdata, e.rdata);
          check("i_rdata_idle", i_pmem_rdata, 128'h0);
        end
      end else begin
        check("i_resp_early", i_pmem_resp, 0);
        check("d_resp_early", d_pmem_resp, 0);
        if (drop_mid && c == 1) begin
          if (e.who == GRANT_I) begin
            i_pmem_read = 1'b0; i_pmem_address = 16'h3333;
          end else begin
            d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = 16'h3333;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    if (!keep_req) begin
      if (e.who == GRANT_I) i_pmem_read = 1'b0;
      else begin
        d_pmem_read = 1'b0; d_pmem_write = 1'b0;
      end
    end
  endtask

  task automatic applyReset();
    reset_n = 1'b0;
    #1;
    check("rst_pmem_read", pmem_read, 0);
    check("rst_pmem_write", pmem_write, 0);
    check("rst_pmem_address", pmem_address, 0);
    check("rst_pmem_wdata", pmem_wdata, 0);
    check("rst_i_resp", i_pmem_resp, 0);
    check("rst_d_resp", d_pmem_resp, 0);
  endtask

  initial begin
    bit seen;
    vectors = 0;
    miscompares = 0;
    i_pmem_read = 0; i_pmem_address = '0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 0;

    applyReset();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // First tie after reset: D wins, then I two idle cycles later.
    i_pmem_read = 1; i_pmem_address = 16'h0040;
    d_pmem_read = 1; d_pmem_address = 16'h8000;
    push(GRANT_D, 16'h8000, 1'b0, '0, pattern(16'h8000));
    push(GRANT_I, 16'h0040, 1'b0, '0, pattern(16'h0040));
    serve(2, 2, 1'b0, 1'b0);
    serve(3, 2, 1'b0, 1'b0);

    // D write-back; the simultaneous read is ignored.
    d_pmem_write = 1; d_pmem_read = 1; d_pmem_address = 16'h7F00;
    d_pmem_wdata = {16{8'hA5}};
    push(GRANT_D, 16'h7F00, 1'b1, {16{8'hA5}}, pattern(16'h7F00));
    serve(3, 2, 1'b0, 1'b0);
    d_pmem_wdata = '0;

    // Single I read, memory latency 3.
    i_pmem_read = 1; i_pmem_address = 16'h1230;
    push(GRANT_I, 16'h1230, 1'b0, '0, 128'h0123_4567_89AB_CDEF_0011_2233_4455_DEAD);
    serve(3, 3, 1'b0, 1'b0);

    // Continuous load from both: grants alternate starting with D.
    i_pmem_read = 1; i_pmem_address = 16'h0A00;
    d_pmem_read = 1; d_pmem_address = 16'hB000;
    for (int n = 0; n < 3; n++) begin
      push(GRANT_D, 16'hB000, 1'b0, '0, pattern(16'hB000 + 16'(n)));
      push(GRANT_I, 16'h0A00, 1'b0, '0, pattern(16'h0A00 + 16'(n)));
    end
    for (int n = 0; n < 6; n++) begin
      serve(n == 0 ? 3 : 3, 2, (n < 4), 1'b0);
    end

    // D drops its request and moves its address mid-grant.
    d_pmem_read = 1; d_pmem_address = 16'h2000;
    push(GRANT_D, 16'h2000, 1'b0, '0, pattern(16'h2000));
    serve(3, 4, 1'b0, 1'b1);

    // Stray memory response while idle.
    repeat (3) @(negedge clk);
    pmem_resp = 1; pmem_rdata = '1;
    #1;
    check("stray_i_resp", i_pmem_resp, 0);
    check("stray_d_resp", d_pmem_resp, 0);
    check("stray_i_rdata", i_pmem_rdata, 128'h0);
    check("stray_d_rdata", d_pmem_rdata, 128'h0);
    check("stray_pmem_read", pmem_read, 0);
    @(posedge clk);
    #1;
    pmem_resp = 0; pmem_rdata = '0;
    repeat (2) @(negedge clk);
    check("stray_no_grant", pmem_read | pmem_write, 0);

    // Reset during an I grant, then a tie must go to D again.
    @(posedge clk);
    #1;
    i_pmem_read = 1; i_pmem_address = 16'h0100;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (pmem_read) seen = 1;
    end
    check("midrst_grant_seen", seen, 1);
    d_pmem_read = 1; d_pmem_address = 16'h0200;
    applyReset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    push(GRANT_D, 16'h0200, 1'b0, '0, pattern(16'h0200));
    push(GRANT_I, 16'h0100, 1'b0, '0, pattern(16'h0100));
    serve(2, 2, 1'b0, 1'b0);
    serve(3, 2, 1'b0, 1'b0);

    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
